// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam int unsigned WORD_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus: instruction memory port, redirect input and decode handshake.
interface fetch_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_plus4,
    input  imem_rdata, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_plus4,
    output imem_rdata, redirect_valid, redirect_pc, id_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, instr} pairs with wrap-around pointers.
// Flush empties the queue and has priority over push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  fetch_entry_t     push_data_i,
  input  logic             pop_i,
  output logic [CNT_W-1:0] count_o,
  output fetch_entry_t     head_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next pointer/count; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; when full, a simultaneous pop frees the slot being written.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: program counter, one-deep in-flight read slot
// and a decode queue. Redirects flush the queue and drop the in-flight read.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             if_valid_q, if_valid_d;
  logic [31:0]      if_pc_q;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occupancy;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;
  logic             head_valid;
  logic             pop;
  logic             issue;
  logic             unused_redirect_lsbs;

  assign head_valid = (count != '0);
  assign pop        = head_valid & bus.id_ready;

  // Entries held or still owed to the queue once this cycle's pop retires;
  // pop implies count >= 1 so this never underflows.
  assign occupancy = {1'b0, count} + (CNT_W + 1)'(if_valid_q) - (CNT_W + 1)'(pop);
  assign issue     = !rst && !bus.redirect_valid && (occupancy < DEPTH_C);

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc_q;

  // Next PC and in-flight flag; redirect wins over a new issue.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if_valid_d = 1'b0;
    if (bus.redirect_valid) begin
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + 32'(WORD_BYTES);
      if_valid_d = 1'b1;
    end
  end

  // PC and in-flight flag register; reset dominates redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      if_valid_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      if_valid_q <= if_valid_d;
    end
  end

  // Remember the address of the outstanding read to pair with its data.
  always_ff @(posedge clk) begin
    if (issue) if_pc_q <= fetch_pc_q;
  end

  assign push_entry.pc    = if_pc_q;
  assign push_entry.instr = bus.imem_rdata;

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (bus.redirect_valid),
    .push_i      (if_valid_q),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .count_o     (count),
    .head_o      (head)
  );

  assign bus.id_valid    = head_valid;
  assign bus.id_instr    = head_valid ? head.instr : NOP_INSTR;
  assign bus.id_pc       = head_valid ? head.pc : 32'h0000_0000;
  assign bus.id_pc_plus4 = head_valid ? (head.pc + 32'(WORD_BYTES)) : 32'(WORD_BYTES);

  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

endmodule
